// File: rtl/stoch_pkg.sv
// Shared types and helpers for the signed stochastic decode datapath.
package stoch_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Accumulator spans +/-2^window_bits, which needs two bits beyond the window.
  function automatic int decode_width(input int window_bits);
    return window_bits + 2;
  endfunction

endpackage

// File: rtl/stoch_signed_decode.sv
// Single-element up/down accumulator for a signed (_p/_m) stochastic stream.
module stoch_signed_decode
  import stoch_pkg::*;
#(
  parameter int WINDOW_BITS = 8,
  localparam int W = decode_width(WINDOW_BITS)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                clear,
  input  logic                en,
  input  logic                a_p,
  input  logic                a_m,
  input  logic                load,
  output logic signed [W-1:0] y
);

  logic signed [W-1:0] acc;
  logic signed [W-1:0] delta;

  always_comb begin
    delta = '0;
    if (a_p && !a_m)      delta = W'(1);
    else if (a_m && !a_p) delta = '1;
  end

  // The final sample is folded into y directly; acc restarts so a
  // back-to-back window begins from zero without a separate clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc <= '0;
      y   <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      if (load) begin
        y   <= acc + delta;
        acc <= '0;
      end else begin
        acc <= acc + delta;
      end
    end
  end

endmodule

// File: rtl/stoch_signed_decode_mat.sv
// Matrix decoder: shared window counter/FSM over per-element accumulators.
// Optional STOCH_DECODE_CONTINUOUS_EN: windows repeat back to back after one START.
//
// state | meaning
// IDLE  | waiting for START; Y holds the last decoded window
// ACCUM | counting enabled samples of the current window
module stoch_signed_decode_mat
  import stoch_pkg::*;
#(
  parameter int NUM_ROWS    = 2,
  parameter int NUM_COLS    = 2,
  parameter int WINDOW_BITS = 8
) (
  input  logic                                                CLK,
  input  logic                                                RST,
  input  logic                                                EN,
  input  logic                                                START,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                   A_p,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                   A_m,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][WINDOW_BITS+1:0]  Y,
  output logic                                                VALID,
  output logic                                                BUSY
);

`ifdef STOCH_DECODE_CONTINUOUS_EN
  localparam bit CONTINUOUS = 1'b1;
`else
  localparam bit CONTINUOUS = 1'b0;
`endif

  state_t                 state, state_nxt;
  logic [WINDOW_BITS-1:0] win_cnt;
  logic                   start_acc;
  logic                   sample;
  logic                   final_sample;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = ACCUM;
      ACCUM:   if (final_sample && !CONTINUOUS) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSY         = (state == ACCUM);
    start_acc    = (state == IDLE) && START;
    sample       = (state == ACCUM) && EN;
    final_sample = sample && (win_cnt == '1);
  end

  // Counter wraps to zero on the final sample, ready for a continuous restart.
  always_ff @(posedge CLK) begin
    if (RST) begin
      win_cnt <= '0;
      VALID   <= 1'b0;
    end else begin
      VALID <= final_sample;
      if (start_acc)   win_cnt <= '0;
      else if (sample) win_cnt <= win_cnt + 1'b1;
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      stoch_signed_decode #(.WINDOW_BITS(WINDOW_BITS)) u_dec (
        .CLK   (CLK),
        .RST   (RST),
        .clear (start_acc),
        .en    (sample),
        .a_p   (A_p[r][c]),
        .a_m   (A_m[r][c]),
        .load  (final_sample),
        .y     (Y[r][c])
      );
    end
  end

endmodule

// File: tb/tb_stoch_signed_decode_mat.sv
// Self-checking bench for stoch_signed_decode_mat (WINDOW_BITS=4, 2x2).
module tb_stoch_signed_decode_mat;

  localparam int WB = 4;

  typedef logic [1:0][1:0][WB+1:0] y_t;

  typedef struct {
    logic [3:0][15:0] p;        // {e3,e2,e1,e0}, bit i = sample i
    logic [3:0][15:0] m;
    y_t               y;
    bit               tog;      // alternate EN=0 cycles carrying junk bits
    int               restart;  // sample index at which START is re-pulsed, -1 none
  } vec_t;

  logic CLK = 1'b0;
  logic RST, EN, START;
  logic [1:0][1:0] A_p, A_m;
  y_t   Y;
  logic VALID, BUSY;

  int errors = 0;
  int checks = 0;
  y_t sb_q[$];
  vec_t vecs[4];

  stoch_signed_decode_mat #(.NUM_ROWS(2), .NUM_COLS(2), .WINDOW_BITS(WB)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START),
    .A_p(A_p), .A_m(A_m), .Y(Y), .VALID(VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0][15:0] p, input logic [3:0][15:0] m,
                              input int y0, input int y1, input int y2, input int y3,
                              input bit tog, input int restart);
    vec_t v;
    v.p = p; v.m = m; v.tog = tog; v.restart = restart;
    v.y[0][0] = 6'(y0); v.y[0][1] = 6'(y1);
    v.y[1][0] = 6'(y2); v.y[1][1] = 6'(y3);
    return v;
  endfunction

  // Scoreboard: every VALID must match the oldest outstanding window.
  always @(negedge CLK) begin : monitor
    y_t e;
    if (!RST && VALID) begin
      if (sb_q.size() == 0) chk("unexpected_valid", VALID, 1'b0);
      else begin
        e = sb_q.pop_front();
        chk("y_window", Y, e);
      end
    end
  end

  // Called at a negedge; START is asserted immediately so chained calls re-arm in the VALID cycle.
  task automatic run_window(input vec_t v);
    START = 1'b1; EN = 1'b1; A_p = '1; A_m = '0;
    sb_q.push_back(v.y);
    @(negedge CLK);
    chk("busy_after_start", BUSY, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (v.tog) begin
        START = 1'b0; EN = 1'b0; A_p = '1; A_m = '0;
        @(negedge CLK);
      end
      EN = 1'b1;
      START = (i == v.restart);
      for (int e = 0; e < 4; e++) begin
        A_p[e/2][e%2] = v.p[e][i];
        A_m[e/2][e%2] = v.m[e][i];
      end
      @(negedge CLK);
    end
    START = 1'b0; EN = 1'b0; A_p = '0; A_m = '0;
    chk("valid_latency", VALID, 1'b1);
`ifndef STOCH_DECODE_CONTINUOUS_EN
    chk("busy_after_final", BUSY, 1'b0);
`endif
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; EN = 1'b0; A_p = '0; A_m = '0;
    vecs[0] = mk({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, '0, 16, 16, 16, 16, 1'b0, -1);
    vecs[1] = mk({16'h00FF, 16'h0FFF, 16'hFFFF, 16'h0000},
                 {16'hFF00, 16'h0000, 16'hFFFF, 16'hFFFF}, -16, 0, 12, 0, 1'b0, -1);
    vecs[2] = mk({16'hFFFF, 16'hFFFF, 16'h0000, 16'hAAAA},
                 {16'h0000, 16'hFFFF, 16'h000F, 16'h0000}, 8, -4, 0, 16, 1'b1, -1);
    vecs[3] = mk({16'h0000, 16'h5555, 16'h0001, 16'h7FFF},
                 {16'h0000, 16'hAAAA, 16'hFFFF, 16'h8000}, 14, -15, 0, 0, 1'b0, 5);

    repeat (3) @(negedge CLK);
    chk("reset_y", Y, '0);
    chk("reset_valid", VALID, 1'b0);
    chk("reset_busy", BUSY, 1'b0);
    RST = 1'b0;
    @(negedge CLK);

`ifndef STOCH_DECODE_CONTINUOUS_EN
    for (int k = 0; k < 4; k++) run_window(vecs[k]);
    chk("y_hold_after_valid", Y, vecs[3].y);

    // Abort a window with RST at sample 7.
    START = 1'b1; EN = 1'b1; A_p = '1; A_m = '0;
    @(negedge CLK);
    START = 1'b0;
    repeat (7) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_y", Y, '0);
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_valid", VALID, 1'b0);
    repeat (20) @(negedge CLK);
    chk("idle_stays_idle", BUSY, 1'b0);
    run_window(vecs[1]);
`else
    // p=1 for 24 samples then 0: windows decode to +16 then +8.
    START = 1'b1; EN = 1'b1; A_p = '1; A_m = '0;
    sb_q.push_back({4{6'd16}});
    sb_q.push_back({4{6'd8}});
    @(negedge CLK);
    START = 1'b0;
    chk("busy_after_start", BUSY, 1'b1);
    for (int i = 0; i < 32; i++) begin
      A_p = (i < 24) ? '1 : '0;
      @(negedge CLK);
      if (i == 15) begin
        chk("valid_window1", VALID, 1'b1);
        chk("busy_continuous", BUSY, 1'b1);
      end
      if (i == 30) chk("no_early_valid", VALID, 1'b0);
    end
    chk("valid_window2", VALID, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("reset_busy_cont", BUSY, 1'b0);
`endif

    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
